// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the read-side frame parser of the 16-bit async FIFO:
// parser state encoding, default widths, header field positions and a small
// helper that builds the first/last sideband tag carried with each word.
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int LEN_W_DEF   = 12;
    localparam int MAX_LEN_DEF = 2048;

    // Header layout: length in the low bits, the rest is reserved and ignored.
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_RSVD_LSB = HDR_LEN_LSB + LEN_W_DEF;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    // Sideband tag stored next to each payload word: {first, last}.
    function automatic logic [1:0] pay_tag(input logic first, input logic last);
        return {first, last};
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry in-order buffer feeding a registered valid/ready stream.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_push     write i_data this cycle (caller only pushes when o_space=1)
//   i_data     W-bit entry to store
//   i_ready    downstream accept
//   o_valid    head entry valid (entry count != 0)
//   o_data     head entry, stable until accepted
//   o_space    a push this cycle is accepted (not full, or head leaving)
// -----------------------------------------------------------------------------
module stream_skid_buf #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_space
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    // A full buffer can still take a word in the same cycle its head leaves.
    assign o_space = (r_cnt != 2'd2) || w_pop;
    assign w_push  = i_push && o_space;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;

    // Entry storage and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= {W{1'b0}};
            r_tail <= {W{1'b0}};
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_deframer.sv
// -----------------------------------------------------------------------------
// fifo_rd_deframer
// Pops a first-word-fall-through FIFO and parses length-prefixed frames
// (one header word, then len payload words) into a valid/ready stream.
// Ports:
//   rd_clk, rd_rst        read-domain clock, synchronous active-high reset
//   fifo_rd_data          FIFO head word (valid while fifo_empty=0)
//   fifo_empty            FIFO empty flag
//   fifo_rd_en            pop strobe (combinational, never set while empty)
//   m_data/m_first/m_last payload word and frame boundary markers
//   m_valid, m_ready      stream handshake
//   frame_err             one-cycle pulse after an illegal header is popped
//   frame_cnt             frames whose last word was accepted (wrapping)
// -----------------------------------------------------------------------------
module fifo_rd_deframer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [LEN_W-1:0]   r_rem;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic               r_first_pend;
    logic               w_first_pend_nxt;
    logic               r_frame_err;
    logic               w_err_nxt;
    logic [15:0]        r_frame_cnt;
    logic               w_rd_en;
    logic               w_push;
    logic               w_space;
    logic [LEN_W-1:0]   w_len;
    logic [DATA_W+1:0]  w_buf_din;
    logic [DATA_W+1:0]  w_buf_dout;

    assign w_len     = fifo_rd_data[HDR_LEN_LSB +: LEN_W];
    assign w_buf_din = {fifo_rd_data, pay_tag(r_first_pend, r_rem == LEN_W'(1))};

    // Pop decision and parser next-state.
    always_comb begin
        w_rd_en          = 1'b0;
        w_push           = 1'b0;
        w_err_nxt        = 1'b0;
        w_state_nxt      = r_state;
        w_rem_nxt        = r_rem;
        w_first_pend_nxt = r_first_pend;
        if (rd_rst) begin
            w_rd_en = 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    w_rd_en = !fifo_empty;
                    if (w_rd_en) begin
                        if (w_len == {LEN_W{1'b0}}) begin
                            w_err_nxt = 1'b1;
                        end else if (w_len > LEN_W'(MAX_LEN)) begin
                            w_err_nxt   = 1'b1;
                            w_rem_nxt   = w_len;
                            w_state_nxt = S_DROP;
                        end else begin
                            w_rem_nxt        = w_len;
                            w_first_pend_nxt = 1'b1;
                            w_state_nxt      = S_PAY;
                        end
                    end else begin
                        w_state_nxt = S_HDR;
                    end
                end
                S_PAY: begin
                    if (r_rem == {LEN_W{1'b0}}) begin
                        // Unreachable by construction; recover instead of underflowing.
                        w_state_nxt = S_HDR;
                    end else begin
                        w_rd_en = !fifo_empty && w_space;
                        if (w_rd_en) begin
                            w_push           = 1'b1;
                            w_first_pend_nxt = 1'b0;
                            w_rem_nxt        = r_rem - LEN_W'(1);
                            if (r_rem == LEN_W'(1)) begin
                                w_state_nxt = S_HDR;
                            end else begin
                                w_state_nxt = S_PAY;
                            end
                        end else begin
                            w_state_nxt = S_PAY;
                        end
                    end
                end
                S_DROP: begin
                    if (r_rem == {LEN_W{1'b0}}) begin
                        w_state_nxt = S_HDR;
                    end else begin
                        w_rd_en = !fifo_empty;
                        if (w_rd_en) begin
                            w_rem_nxt = r_rem - LEN_W'(1);
                            if (r_rem == LEN_W'(1)) begin
                                w_state_nxt = S_HDR;
                            end else begin
                                w_state_nxt = S_DROP;
                            end
                        end else begin
                            w_state_nxt = S_DROP;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_HDR;
                end
            endcase
        end
    end

    // Parser state, remaining length, error pulse and delivered-frame count.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state      <= S_HDR;
            r_rem        <= {LEN_W{1'b0}};
            r_first_pend <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            r_first_pend <= w_first_pend_nxt;
            r_frame_err  <= w_err_nxt;
            if (m_valid && m_ready && m_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    stream_skid_buf #(
        .W (DATA_W + 2)
    ) u_buf (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .i_push  (w_push),
        .i_data  (w_buf_din),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (w_buf_dout),
        .o_space (w_space)
    );

    assign fifo_rd_en = w_rd_en;
    assign m_data     = w_buf_dout[DATA_W+1:2];
    assign m_first    = w_buf_dout[1];
    assign m_last     = w_buf_dout[0];
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fifo_rd_deframer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_deframer
// Drives a queue-modelled FWFT FIFO into fifo_rd_deframer and checks the
// payload stream against an expected-word list derived from the frames added.
// -----------------------------------------------------------------------------
module tb_fifo_rd_deframer;
    import fifo_rd_pkg::*;

    localparam int ML = 2048;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic [15:0] fifo_rd_data = 16'h0000;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_first;
    logic        m_last;
    logic        frame_err;
    logic [15:0] frame_cnt;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_deframer dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_first      (m_first),
        .m_last       (m_last),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    logic [15:0] src_q[$];    // words not yet written into the FIFO
    logic [15:0] fifo_q[$];   // FIFO contents, head at index 0
    logic [17:0] exp_q[$];    // expected {data, first, last} in delivery order

    int checks = 0;
    int errors = 0;
    int exp_err, err_seen, exp_frames, words_added, rd_en_cnt;
    int acc_cnt, cyc, first_acc_cyc, last_acc_cyc;
    bit ready_rand, feed_rand;
    logic ready_fix;
    bit hold_v;
    logic [17:0] hold_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Appends one frame (header + len words) and extends the expectations.
    task automatic add_frame(input int len, input logic [15:0] base, input bit rand_pay);
        logic [15:0] hdr;
        logic [15:0] w;
        bit legal;
        legal = (len >= 1) && (len <= ML);
        hdr[15:12] = 4'($urandom_range(0, 15));
        hdr[11:0]  = 12'(len);
        src_q.push_back(hdr);
        words_added++;
        if (!legal) exp_err++;
        for (int i = 0; i < len; i++) begin
            w = rand_pay ? 16'($urandom) : base + 16'(i);
            src_q.push_back(w);
            words_added++;
            if (legal) exp_q.push_back({w, 1'(i == 0), 1'(i == len - 1)});
        end
        if (legal) exp_frames++;
    endtask

    // One clock cycle: feed FIFO, drive inputs, observe outputs, advance.
    task automatic step();
        bit pop;
        bit acc;
        if (feed_rand) begin
            if (src_q.size() > 0 && fifo_q.size() < 128 && $urandom_range(0, 9) < 7)
                fifo_q.push_back(src_q.pop_front());
        end else begin
            while (src_q.size() > 0 && fifo_q.size() < 128)
                fifo_q.push_back(src_q.pop_front());
        end
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? 16'h0000 : fifo_q[0];
        m_ready      = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
        #1;
        pop = fifo_rd_en;
        acc = m_valid && m_ready;
        chk("rd_en_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (rd_rst) chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        if (hold_v && !rd_rst)
            chk("hold_stable", 32'({m_valid, m_data, m_first, m_last}), 32'({1'b1, hold_val}));
        if (acc && !rd_rst) begin
            if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 32'd1);
            else chk("payload", 32'({m_data, m_first, m_last}), 32'(exp_q.pop_front()));
            acc_cnt++;
            if (acc_cnt == 1) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
        end
        if (frame_err) err_seen++;
        if (pop) rd_en_cnt++;
        hold_v   = m_valid && !m_ready && !rd_rst;
        hold_val = {m_data, m_first, m_last};
        @(posedge rd_clk);
        #1;
        cyc++;
        if (pop && fifo_q.size() > 0) fifo_q.delete(0);
    endtask

    task automatic clear_model();
        src_q.delete();
        fifo_q.delete();
        exp_q.delete();
        exp_err = 0; err_seen = 0; exp_frames = 0; words_added = 0;
        rd_en_cnt = 0; acc_cnt = 0; first_acc_cyc = 0; last_acc_cyc = 0;
        hold_v = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rd_rst = 1'b1;
        clear_model();
        step();
        step();
        chk({tag, "_rst_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_rst_marks"}, 32'({m_first, m_last}), 32'd0);
        chk({tag, "_rst_data"},  32'(m_data), 32'd0);
        chk({tag, "_rst_err"},   32'(frame_err), 32'd0);
        chk({tag, "_rst_cnt"},   32'(frame_cnt), 32'd0);
        chk({tag, "_rst_state"}, 32'(dut.r_state), 32'(S_HDR));
        rd_rst = 1'b0;
        clear_model();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((src_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0 || m_valid)
               && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain_in_budget"}, 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    task automatic end_test(input string tag);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        chk({tag, "_err_pulses"}, 32'(err_seen), 32'(exp_err));
        chk({tag, "_pops"}, 32'(rd_en_cnt), 32'(words_added));
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int len;
        ready_rand = 1'b0; feed_rand = 1'b0; ready_fix = 1'b1;

        // Single len=3 frame at full rate.
        do_reset("t1");
        add_frame(3, 16'hA001, 1'b0);
        drain("t1", 50);
        end_test("t1");
        chk("t1_consecutive", 32'(last_acc_cyc - first_acc_cyc), 32'd2);

        // Back-to-back frames: one header bubble between them.
        do_reset("t2");
        add_frame(1, 16'h0011, 1'b0);
        add_frame(2, 16'h0022, 1'b0);
        drain("t2", 50);
        end_test("t2");
        chk("t2_span", 32'(last_acc_cyc - first_acc_cyc), 32'd3);

        // Backpressure: buffer fills to two words, popping stops.
        do_reset("t3");
        ready_fix = 1'b0;
        add_frame(4, 16'hB001, 1'b0);
        repeat (6) step();
        chk("t3_pops_while_full", 32'(rd_en_cnt), 32'd3);
        chk("t3_rd_en_full", 32'(fifo_rd_en), 32'd0);
        chk("t3_head", 32'({m_valid, m_data, m_first}), 32'({1'b1, 16'hB001, 1'b1}));
        ready_fix = 1'b1;
        drain("t3", 50);
        end_test("t3");

        // Zero-length header, then a one-word frame.
        do_reset("t4");
        add_frame(0, 16'h0000, 1'b0);
        add_frame(1, 16'h5555, 1'b0);
        drain("t4", 50);
        end_test("t4");

        // Oversize frame dropped, then a one-word frame.
        do_reset("t5");
        add_frame(ML + 1, 16'h0000, 1'b1);
        add_frame(1, 16'h7777, 1'b0);
        drain("t5", 5000);
        end_test("t5");

        // Reset in the middle of a frame.
        do_reset("t6");
        add_frame(1, 16'hC000, 1'b0);
        add_frame(5, 16'hC001, 1'b0);
        n = 0;
        while (acc_cnt < 3 && n < 50) begin
            step();
            n++;
        end
        chk("t6_reach_midframe", 32'(acc_cnt), 32'd3);
        chk("t6_cnt_before_rst", 32'(frame_cnt), 32'd1);
        rd_rst = 1'b1;
        step();
        chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
        chk("t6_cnt_after_rst", 32'(frame_cnt), 32'd0);
        chk("t6_state_after_rst", 32'(dut.r_state), 32'(S_HDR));
        clear_model();
        step();
        rd_rst = 1'b0;
        clear_model();
        add_frame(2, 16'hD001, 1'b0);
        drain("t6", 50);
        end_test("t6");

        // Randomized frames, gaps and backpressure, including length boundaries.
        do_reset("t7");
        ready_rand = 1'b1;
        feed_rand  = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            add_frame(len, 16'h0000, 1'b1);
            if (f == 15) add_frame(ML, 16'h0000, 1'b1);
            if (f == 25) add_frame(int'($urandom_range(ML + 1, ML + 40)), 16'h0000, 1'b1);
        end
        drain("t7", 30000);
        end_test("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_deframer.md
Name: fifo_rd_deframer

Overview:
- Read-side consumer of the 16-bit, 128-deep asynchronous FIFO, living entirely in the read clock domain.
- Pops words from the FIFO's first-word-fall-through read port and parses them as length-prefixed frames: one header word followed by N payload words.
- Presents payload on a registered valid/ready stream with first/last markers.
- Guarantees full throughput (one word per cycle) under continuous m_ready, using a 2-entry output buffer.

Parameters:
- DATA_W, 16, FIFO word and stream data width.
- LEN_W, 12, header length field width (header bits [LEN_W-1:0]).
- MAX_LEN, 2048, largest legal payload length in words; must be ≤ 2^LEN_W - 1.

Ports:
- rd_clk  input  1  read-domain clock; all logic is on its rising edge.
- rd_rst  input  1  synchronous, active-high reset.
- fifo_rd_data  input  DATA_W  FIFO head word, valid whenever fifo_empty=0 (FWFT).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  DATA_W? no: 1  pop strobe; head advances at the rd_clk edge where it is high.
- m_data  output  DATA_W  payload word.
- m_valid  output  1  m_data/m_first/m_last valid.
- m_ready  input  1  downstream accept; transfer occurs when m_valid & m_ready.
- m_first  output  1  first payload word of a frame.
- m_last  output  1  final payload word of a frame.
- frame_err  output  1  one-cycle pulse when an illegal header is popped.
- frame_cnt  output  16  count of frames fully delivered (last word accepted); wraps at 0xFFFF→0.

Behaviour:
- Reset (rd_rst=1 at a clock edge):
  - State goes to S_HDR; buffer is emptied; counters are cleared.
  - m_valid=0, m_first=0, m_last=0, m_data=0, frame_err=0, frame_cnt=0.
  - fifo_rd_en is held 0 while rd_rst=1.
  - Reset mid-frame abandons the frame; remaining payload in the FIFO is parsed as headers (FIFO is reset in the same domain by system convention).
- fifo_rd_en is combinational and never asserted when fifo_empty=1.
- Header format: bits [LEN_W-1:0] = len; bits [DATA_W-1:LEN_W] are reserved and ignored.
- S_HDR (header parsing):
  - fifo_rd_en = !fifo_empty.
  - On pop with 1 ≤ len ≤ MAX_LEN: load rem=len, set first_pending=1, go to S_PAY.
  - On pop with len=0: pulse frame_err the next cycle, stay in S_HDR.
  - On pop with len>MAX_LEN: pulse frame_err, load rem=len, go to S_DROP.
- S_PAY (payload delivery):
  - Define space = (buf_cnt<2) || (m_valid && m_ready).
  - fifo_rd_en = !fifo_empty && space.
  - Each pop writes the word into the 2-entry buffer, tagged with first=first_pending and last=(rem==1).
  - Each pop clears first_pending and decrements rem.
  - When rem reaches 0, go to S_HDR. The next header may be popped in the following cycle, even while the buffer still holds this frame's words.
- S_DROP (discarding an oversize frame):
  - fifo_rd_en = !fifo_empty.
  - Popped words are discarded and rem decrements on each pop.
  - At rem==0 go to S_HDR. Nothing is emitted and frame_cnt is unchanged.
- Output buffer:
  - In-order FIFO with 2 entries; the head entry drives m_*, and m_valid = (buf_cnt≠0).
  - Latency: a word popped at edge k is visible on m_data after edge k (valid in cycle k+1).
  - Simultaneous push and pop keeps buf_cnt constant.
  - m_data/m_first/m_last hold stable while m_valid & !m_ready (AXI-style: no retraction).
- frame_cnt increments on the edge where m_valid & m_ready & m_last.
- Throughput:
  - Continuous m_ready=1 with a non-empty FIFO gives one payload word per cycle.
  - Each header costs one bubble cycle.
  - If m_ready is low for ≥2 cycles, popping stops once buf_cnt=2.
- len is sampled only at the header pop; rem never underflows.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - State enum: S_HDR=2'd0, S_PAY=2'd1, S_DROP=2'd2.
  - DATA_W and LEN_W defaults.
  - Header field slice constants.
- Sub-module: stream_skid_buf, the 2-entry buffer with push/pop/space and DATA_W+2 bits of payload.
- FSM, counters and pop logic live in the top level.

Test Plan:
- Header len=3, payload 0xA001/0xA002/0xA003, m_ready=1 → three transfers on consecutive cycles; m_first on 0xA001, m_last on 0xA003; frame_cnt 0→1; exactly 4 fifo_rd_en pulses.
- Back-to-back frames len=1 (0x0011) and len=2 (0x0022, 0x0023) → outputs 0x0011(first,last), 0x0022(first), 0x0023(last), with one-cycle header bubbles; frame_cnt=2.
- Backpressure: len=4, m_ready=0 for 5 cycles then 1 → buf_cnt saturates at 2 and fifo_rd_en stays 0 while full; m_data holds 0xB001; all 4 words delivered in order afterwards.
- Header 0x0000, then header len=1 with 0x5555 → frame_err pulses once; 0x5555 is delivered with first=last=1.
- Header len=2049 (MAX_LEN=2048) with 2049 filler words, then len=1 with 0x7777 → one frame_err pulse, 2050 pops, no m_valid until 0x7777; frame_cnt=1.
- rd_rst asserted mid-frame (after 2 of 5 words) → the next cycle shows m_valid=0, frame_cnt=0, state S_HDR, and fifo_rd_en=0 during reset.
